// File: rtl/imem_loader.sv
// imem_loader: bit-serial program loader for the instruction buffer.
// Assembles buffer lines MSB-first from a valid/ready serial stream.
// Each line goes out as a single-cycle write at auto-incrementing addresses.
// The PAT core is held in reset for the whole load.
module imem_loader #(
   parameter int i_adr_width   = 10,
   parameter int i_width       = 23,
   parameter int i_buffer_size = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [i_adr_width-1:0]               base_adr,
   input  logic [i_adr_width-1:0]               word_count,
   input  logic                                 ser_valid,
   input  logic                                 ser_data,
   output logic                                 ser_ready,
   output logic [i_adr_width-1:0]               imem_write_adr,
   output logic                                 imem_write,
   output logic [i_buffer_size*i_width-1:0]     imem_in,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 pat_hold,
   output logic                                 err
);

   localparam int LW  = i_buffer_size * i_width;
   localparam int BCW = $clog2(LW);

   localparam logic [BCW-1:0]         LAST_BIT = BCW'(LW - 1);
   localparam logic [i_adr_width-1:0] ONE_LINE = i_adr_width'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [LW-1:0]           shreg_q;
   logic [BCW-1:0]          bitcnt_q;
   logic [i_adr_width-1:0]  remaining_q;
   logic [i_adr_width-1:0]  adr_q;
   logic                    err_q;

   // Registered write port: data, address and strobe travel together
   logic [LW-1:0]           line_p1;
   logic [i_adr_width-1:0]  adr_p1;
   logic                    vld_p1;

   logic                    load;
   logic                    accept;
   logic                    last_bit;
   logic                    last_line;
   logic [LW-1:0]           shreg_next;

   assign load       = (state_q == S_IDLE) && start && (word_count != '0);
   assign accept     = (state_q == S_SHIFT) && ser_valid;
   assign last_bit   = accept && (bitcnt_q == LAST_BIT);
   assign last_line  = (remaining_q == ONE_LINE);
   assign shreg_next = {shreg_q[LW-2:0], ser_data};

   // Next-state decode; start outside IDLE is deliberately ignored
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (word_count == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (last_bit) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            state_d = last_line ? S_DONE : S_SHIFT;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register; reset abandons any load in progress
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Line assembly: shift register and bit counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg_q  <= '0;
         bitcnt_q <= '0;
      end else if (load) begin
         bitcnt_q <= '0;
      end else if (accept) begin
         shreg_q  <= shreg_next;
         bitcnt_q <= last_bit ? '0 : bitcnt_q + 1'b1;
      end
   end

   // Address and remaining-line bookkeeping; address wraps modulo 2^i_adr_width
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         adr_q       <= '0;
         remaining_q <= '0;
      end else if (load) begin
         adr_q       <= base_adr;
         remaining_q <= word_count;
      end else if ((state_q == S_WRITE) && !last_line) begin
         adr_q       <= adr_q + 1'b1;
         remaining_q <= remaining_q - 1'b1;
      end
   end

   // ---- stage p1: write port, loaded as the final bit of a line arrives ----
   // Data and address hold their last written values between writes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1  <= 1'b0;
         line_p1 <= '0;
         adr_p1  <= '0;
      end else begin
         vld_p1 <= last_bit;
         if (last_bit) begin
            line_p1 <= shreg_next;
            adr_p1  <= adr_q;
         end
      end
   end

   // Sticky error: a bit offered during the write cycle is dropped and flagged
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (load) begin
         err_q <= 1'b0;
      end else if ((state_q == S_WRITE) && ser_valid) begin
         err_q <= 1'b1;
      end
   end

   assign ser_ready      = (state_q == S_SHIFT);
   assign busy           = (state_q == S_SHIFT) || (state_q == S_WRITE);
   assign pat_hold       = busy;
   assign done           = (state_q == S_DONE);
   assign imem_write     = vld_p1;
   assign imem_in        = line_p1;
   assign imem_write_adr = adr_p1;
   assign err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenario tests for imem_loader.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [9:0]  base_adr;
   logic [9:0]  word_count;
   logic        ser_valid;
   logic        ser_data;
   logic        ser_ready;
   logic [9:0]  imem_write_adr;
   logic        imem_write;
   logic [45:0] imem_in;
   logic        busy;
   logic        done;
   logic        pat_hold;
   logic        err;

   int errors = 0;
   int checks = 0;
   int wr_n   = 0;

   imem_loader #(
      .i_adr_width   (10),
      .i_width       (23),
      .i_buffer_size (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .base_adr       (base_adr),
      .word_count     (word_count),
      .ser_valid      (ser_valid),
      .ser_data       (ser_data),
      .ser_ready      (ser_ready),
      .imem_write_adr (imem_write_adr),
      .imem_write     (imem_write),
      .imem_in        (imem_in),
      .busy           (busy),
      .done           (done),
      .pat_hold       (pat_hold),
      .err            (err)
   );

   always #5 clk = ~clk;

   // Count write strobes, sampled mid-cycle
   always @(negedge clk) begin
      if (imem_write === 1'b1) wr_n <= wr_n + 1;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic begin_load(input logic [9:0] adr, input logic [9:0] cnt);
      start      = 1'b1;
      base_adr   = adr;
      word_count = cnt;
      step();
      start = 1'b0;
   endtask

   // Stream the top nbits of d MSB-first; optionally with gaps and a stray start
   task automatic send_line(input logic [45:0] d, input int nbits, input bit gaps, input bit inj);
      int sent;
      int budget;
      int idx;
      bit acc;
      sent   = 0;
      budget = 0;
      while (sent < nbits && budget < 2000) begin
         idx       = 45 - sent;
         ser_data  = d[idx];
         ser_valid = (gaps ? ($urandom_range(0, 1) != 0) : 1'b1) && ser_ready;
         if (inj && idx == 20) begin
            start      = 1'b1;
            base_adr   = 10'd100;
            word_count = 10'd7;
         end
         acc = ser_valid;
         step();
         start = 1'b0;
         if (acc) sent++;
         budget++;
      end
      ser_valid = 1'b0;
      checks++;
      if (sent != nbits) begin
         errors++;
         $display("FAIL send_line_timeout: sent=%0d required=%0d", sent, nbits);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; base_adr = '0; word_count = '0;
      ser_valid = 1'b0; ser_data = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (imem_write !== 1'b0) begin errors++; $display("FAIL rst_write: got=%0b exp=0", imem_write); end
      checks++; if (imem_write_adr !== 10'd0) begin errors++; $display("FAIL rst_adr: got=%0d exp=0", imem_write_adr); end
      checks++; if (imem_in !== 46'd0) begin errors++; $display("FAIL rst_data: got=%h exp=0", imem_in); end
      checks++; if (busy !== 1'b0 || pat_hold !== 1'b0) begin errors++; $display("FAIL rst_busy: busy=%0b hold=%0b exp=0", busy, pat_hold); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_done_err: done=%0b err=%0b exp=0", done, err); end
      checks++; if (ser_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got=%0b exp=0", ser_ready); end
      reset = 1'b1;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle: busy=%0b exp=0", busy); end
   endtask

   task automatic test_single_line;
      int w0;
      logic [45:0] d;
      d  = 46'h2AAAAAAAAAAA;
      w0 = wr_n;
      begin_load(10'd5, 10'd1);
      checks++; if (busy !== 1'b1 || pat_hold !== 1'b1) begin errors++; $display("FAIL single_busy: busy=%0b hold=%0b exp=1", busy, pat_hold); end
      checks++; if (ser_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got=%0b exp=1", ser_ready); end
      send_line(d, 46, 1'b0, 1'b0);
      checks++; if (imem_write !== 1'b1) begin errors++; $display("FAIL single_wr: got=%0b exp=1", imem_write); end
      checks++; if (imem_write_adr !== 10'd5) begin errors++; $display("FAIL single_adr: got=%0d exp=5", imem_write_adr); end
      checks++; if (imem_in !== d) begin errors++; $display("FAIL single_data: got=%h exp=%h", imem_in, d); end
      checks++; if (busy !== 1'b1 || ser_ready !== 1'b0) begin errors++; $display("FAIL single_wrcyc: busy=%0b ready=%0b exp 1/0", busy, ser_ready); end
      step();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got=%0b exp=1", done); end
      checks++; if (busy !== 1'b0 || pat_hold !== 1'b0 || imem_write !== 1'b0) begin errors++; $display("FAIL single_donecyc: busy=%0b hold=%0b wr=%0b exp=0", busy, pat_hold, imem_write); end
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got=%0b exp=0", done); end
      checks++; if (imem_in !== d) begin errors++; $display("FAIL single_hold: got=%h exp=%h", imem_in, d); end
      checks++; if (wr_n - w0 != 1) begin errors++; $display("FAIL single_wrcount: got=%0d exp=1", wr_n - w0); end
   endtask

   task automatic test_wrap_gaps;
      logic [45:0] dl [3];
      logic [9:0]  ea;
      int w0;
      dl[0] = 46'h123456789ABC;
      dl[1] = 46'h3FEDCBA98765;
      dl[2] = 46'h0F0F0F0F0F0F;
      w0 = wr_n;
      begin_load(10'd1023, 10'd3);
      for (int k = 0; k < 3; k++) begin
         ea = 10'd1023 + 10'(k);
         send_line(dl[k], 46, 1'b1, 1'b0);
         checks++; if (imem_write !== 1'b1 || imem_write_adr !== ea) begin errors++; $display("FAIL wrap_adr%0d: wr=%0b adr=%0d exp adr=%0d", k, imem_write, imem_write_adr, ea); end
         checks++; if (imem_in !== dl[k]) begin errors++; $display("FAIL wrap_data%0d: got=%h exp=%h", k, imem_in, dl[k]); end
         checks++; if (ser_ready !== 1'b0) begin errors++; $display("FAIL wrap_ready%0d: got=%0b exp=0", k, ser_ready); end
      end
      step();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done: got=%0b exp=1", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got=%0b exp=0", err); end
      step();
      checks++; if (wr_n - w0 != 3) begin errors++; $display("FAIL wrap_wrcount: got=%0d exp=3", wr_n - w0); end
   endtask

   task automatic test_noop;
      int w0;
      w0 = wr_n;
      ser_valid = 1'b1;
      step();
      ser_valid = 1'b0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL idle_valid_err: got=%0b exp=0", err); end
      begin_load(10'd3, 10'd0);
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL noop_done: done=%0b busy=%0b exp 1/0", done, busy); end
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL noop_after: done=%0b busy=%0b exp 0/0", done, busy); end
      checks++; if (wr_n - w0 != 0) begin errors++; $display("FAIL noop_wrcount: got=%0d exp=0", wr_n - w0); end
   endtask

   task automatic test_start_busy;
      logic [45:0] d0, d1;
      d0 = 46'h155555555555;
      d1 = 46'h0000FFFF0001;
      begin_load(10'd40, 10'd2);
      send_line(d0, 46, 1'b0, 1'b1);
      checks++; if (imem_write_adr !== 10'd40 || imem_in !== d0) begin errors++; $display("FAIL busy_start0: adr=%0d data=%h exp 40/%h", imem_write_adr, imem_in, d0); end
      send_line(d1, 46, 1'b0, 1'b0);
      checks++; if (imem_write_adr !== 10'd41 || imem_in !== d1) begin errors++; $display("FAIL busy_start1: adr=%0d data=%h exp 41/%h", imem_write_adr, imem_in, d1); end
      step();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_start_done: got=%0b exp=1", done); end
      step();
   endtask

   task automatic test_reset_mid;
      int w0;
      logic [45:0] d;
      d  = 46'h3C3C3C3C3C3C;
      w0 = wr_n;
      begin_load(10'd200, 10'd3);
      send_line(46'h111111111111, 46, 1'b0, 1'b0);
      send_line(46'h222222222222, 30, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || pat_hold !== 1'b0 || ser_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: busy=%0b hold=%0b ready=%0b exp=0", busy, pat_hold, ser_ready); end
      checks++; if (imem_in !== 46'd0 || imem_write_adr !== 10'd0 || imem_write !== 1'b0) begin errors++; $display("FAIL rstmid_port: data=%h adr=%0d wr=%0b exp=0", imem_in, imem_write_adr, imem_write); end
      step();
      step();
      reset = 1'b1;
      step();
      checks++; if (wr_n - w0 != 1) begin errors++; $display("FAIL rstmid_wrcount: got=%0d exp=1", wr_n - w0); end
      begin_load(10'd7, 10'd1);
      send_line(d, 46, 1'b0, 1'b0);
      checks++; if (imem_write !== 1'b1 || imem_write_adr !== 10'd7 || imem_in !== d) begin errors++; $display("FAIL rstmid_fresh: wr=%0b adr=%0d data=%h exp 1/7/%h", imem_write, imem_write_adr, imem_in, d); end
      step();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done: got=%0b exp=1", done); end
      step();
   endtask

   task automatic test_proto_err;
      logic [45:0] d1;
      d1 = 46'h2468ACE13579;
      begin_load(10'd10, 10'd2);
      send_line(46'h000000000001, 46, 1'b0, 1'b0);
      checks++; if (imem_write !== 1'b1 || imem_write_adr !== 10'd10) begin errors++; $display("FAIL perr_wr0: wr=%0b adr=%0d exp 1/10", imem_write, imem_write_adr); end
      ser_valid = 1'b1;
      ser_data  = 1'b1;
      step();
      ser_valid = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL perr_set: got=%0b exp=1", err); end
      send_line(d1, 46, 1'b0, 1'b0);
      checks++; if (imem_in !== d1 || imem_write_adr !== 10'd11) begin errors++; $display("FAIL perr_next: data=%h adr=%0d exp %h/11", imem_in, imem_write_adr, d1); end
      step();
      checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL perr_sticky: done=%0b err=%0b exp 1/1", done, err); end
      step();
      begin_load(10'd0, 10'd1);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL perr_clear: got=%0b exp=0", err); end
      send_line(46'h3FFFFFFFFFFF, 46, 1'b0, 1'b0);
      step();
      step();
   endtask

   initial begin
      test_reset();
      test_single_line();
      test_wrap_gaps();
      test_noop();
      test_start_busy();
      test_reset_mid();
      test_proto_err();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
